// File: rtl/mgmt_gpio_pkg.sv
// Shared register indices and reset constants for the management GPIO endpoint.
package mgmt_gpio_pkg;

  localparam logic [2:0] ADDR_OUT  = 3'd0;
  localparam logic [2:0] ADDR_OEB  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_RISE = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_PEND = 3'd5;

  // Wide constants; users slice them down to NPADS / NOEB bits.
  localparam logic [31:0] OEB_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] OUT_RST = 32'h0000_0000;

endpackage

// File: rtl/mgmt_gpio_in_sync.sv
// One pad input: 2-flop synchronizer, optional debouncer (MGMT_GPIO_DEBOUNCE_EN)
// and a one-cycle delayed copy of the stable value for edge detection.
module mgmt_gpio_in_sync #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic pad_in,
  output logic data_in,
  output logic data_dly
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;
  logic data_s;

`ifdef MGMT_GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          data_q;
  logic          data_d;

  // Accept a new level only after it has been seen DEB_CYCLES times in a row.
  always_comb begin
    data_d = data_q;
    cnt_d  = {CW{1'b0}};
    if (sync2_q != data_q) begin
      if (cnt_q == CNT_MAX) begin
        data_d = sync2_q;
        cnt_d  = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Debounce state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= {CW{1'b0}};
      data_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data_s = data_q;
`else
  localparam int deb_cycles_unused = DEB_CYCLES;

  assign data_s = sync2_q;
`endif

  // Synchronizer and delayed copy; both reset to 0 so no edge follows reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      dly_q   <= data_s;
    end
  end

  assign data_in  = data_s;
  assign data_dly = dly_q;

endmodule

// File: rtl/mgmt_gpio_ctrl.sv
// Register-side endpoint for the buffered management GPIO bus.
// Define MGMT_GPIO_DEBOUNCE_EN to insert a per-pad debouncer in the input path.
module mgmt_gpio_ctrl #(
  parameter int NPADS      = 19,
  parameter int NOEB       = 3,
  parameter int DEB_CYCLES = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [NPADS-1:0] gpio_in_buf,
  output logic [NPADS-1:0] gpio_out,
  output logic [NOEB-1:0]  gpio_oeb,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic             irq
);
  import mgmt_gpio_pkg::*;

  logic [NPADS-1:0] data_in_s, data_dly_s, events_s, w1c_s;
  logic [NPADS-1:0] out_q, out_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d, pend_q, pend_d;
  logic [NOEB-1:0]  oeb_q, oeb_d;
  logic [31:0]      rd_mux_s, rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, irq_q, irq_d;
  logic             wdata_unused_s;

  assign wdata_unused_s = ^reg_wdata[31:NPADS];

  for (genvar i = 0; i < NPADS; i++) begin : g_pad
    mgmt_gpio_in_sync #(.DEB_CYCLES(DEB_CYCLES)) u_in_sync (
      .clock    (clock),
      .resetn   (resetn),
      .pad_in   (gpio_in_buf[i]),
      .data_in  (data_in_s[i]),
      .data_dly (data_dly_s[i])
    );
  end

  // Register writes, edge events and pending/irq update; a new event beats a W1C.
  always_comb begin
    out_d     = out_q;
    oeb_d     = oeb_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = {NPADS{1'b0}};
    if (reg_wr) begin
      case (reg_addr)
        ADDR_OUT:  out_d     = reg_wdata[NPADS-1:0];
        ADDR_OEB:  oeb_d     = reg_wdata[NOEB-1:0];
        ADDR_RISE: rise_en_d = reg_wdata[NPADS-1:0];
        ADDR_FALL: fall_en_d = reg_wdata[NPADS-1:0];
        ADDR_PEND: w1c_s     = reg_wdata[NPADS-1:0];
        default:   w1c_s     = {NPADS{1'b0}};
      endcase
    end else begin
      w1c_s = {NPADS{1'b0}};
    end
    events_s = (data_in_s & ~data_dly_s & rise_en_q) | (~data_in_s & data_dly_s & fall_en_q);
    pend_d   = (pend_q & ~w1c_s) | events_s;
    irq_d    = |pend_d;
  end

  // Read mux sees pre-write state; rdata holds between reads.
  always_comb begin
    case (reg_addr)
      ADDR_OUT:  rd_mux_s = 32'(out_q);
      ADDR_OEB:  rd_mux_s = 32'(oeb_q);
      ADDR_IN:   rd_mux_s = 32'(data_in_s);
      ADDR_RISE: rd_mux_s = 32'(rise_en_q);
      ADDR_FALL: rd_mux_s = 32'(fall_en_q);
      ADDR_PEND: rd_mux_s = 32'(pend_q);
      default:   rd_mux_s = 32'h0000_0000;
    endcase
    if (reg_rd) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
    rvalid_d = reg_rd;
  end

  // Register state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q     <= OUT_RST[NPADS-1:0];
      oeb_q     <= OEB_RST[NOEB-1:0];
      rise_en_q <= {NPADS{1'b0}};
      fall_en_q <= {NPADS{1'b0}};
      pend_q    <= {NPADS{1'b0}};
      rdata_q   <= 32'h0000_0000;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oeb_q     <= oeb_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
    end
  end

  assign gpio_out   = out_q;
  assign gpio_oeb   = oeb_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Scoreboard bench for mgmt_gpio_ctrl: read expectations are queued at issue
// and popped when reg_rvalid appears; direct output checks go through chk.
module tb_mgmt_gpio_ctrl;

`ifdef MGMT_GPIO_DEBOUNCE_EN
  localparam int IN_LAT = 10;
`else
  localparam int IN_LAT = 2;
`endif

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [18:0] gpio_in_buf = 19'h0;
  logic [18:0] gpio_out;
  logic [2:0]  gpio_oeb;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        irq;

  int checks = 0;
  int errors = 0;
  rd_exp_t exp_q[$];

  mgmt_gpio_ctrl #(.NPADS(19), .NOEB(3), .DEB_CYCLES(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .gpio_in_buf (gpio_in_buf),
    .gpio_out    (gpio_out),
    .gpio_oeb    (gpio_oeb),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    cyc();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, input logic [31:0] e);
    rd_exp_t it;
    it.addr = a; it.data = e;
    exp_q.push_back(it);
    reg_rd = 1'b1; reg_addr = a;
    cyc();
    reg_rd = 1'b0;
  endtask

  // Scoreboard: compare every read response against the oldest expectation.
  always @(negedge clock) begin
    if (resetn === 1'b1 && reg_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        rd_exp_t it;
        it = exp_q.pop_front();
        chk($sformatf("rdata_addr%0d", it.addr), reg_rdata, it.data);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_oeb", 32'(gpio_oeb), 32'h7);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'h0);
    resetn = 1'b1;
    cyc();
    reg_read(3'd1, 32'h7);
    reg_read(3'd0, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    // Writes land on the strobe edge; upper data bits ignored
    reg_write(3'd0, 32'hFFF5_A5A5);
    chk("out_same_edge", 32'(gpio_out), 32'h5A5A5);
    reg_write(3'd1, 32'hFFFF_FFFA);
    chk("oeb_same_edge", 32'(gpio_oeb), 32'h2);
    reg_read(3'd0, 32'h5A5A5);
    reg_read(3'd1, 32'h2);

    // Simultaneous write and read of OUT returns the old value
    exp_q.push_back('{3'd0, 32'h5A5A5});
    reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h0001_2345;
    cyc();
    reg_wr = 1'b0; reg_rd = 1'b0;
    chk("out_after_wr_rd", 32'(gpio_out), 32'h12345);
    reg_read(3'd0, 32'h12345);
    repeat (3) cyc();
    chk("rdata_hold", reg_rdata, 32'h12345);
    chk("rvalid_pulse", 32'(reg_rvalid), 32'h0);

    // Reserved addresses and idle input register
    reg_write(3'd6, 32'hFFFF_FFFF);
    reg_read(3'd6, 32'h0);
    reg_read(3'd7, 32'h0);
    reg_read(3'd2, 32'h0);

    // Enabled rising edge on bit 0
    reg_write(3'd3, 32'h1);
    gpio_in_buf[0] = 1'b1;
    repeat (IN_LAT) cyc();
    chk("irq_before_pend", 32'(irq), 32'h0);
    reg_read(3'd2, 32'h1);
    chk("irq_rise0", 32'(irq), 32'h1);
    reg_read(3'd5, 32'h1);

    // Falling edge with FALL_EN clear changes nothing
    gpio_in_buf[0] = 1'b0;
    repeat (IN_LAT + 3) cyc();
    reg_read(3'd5, 32'h1);
    reg_read(3'd2, 32'h0);

    // New event and W1C on the same edge: set wins
    gpio_in_buf[0] = 1'b1;
    repeat (IN_LAT) cyc();
    reg_write(3'd5, 32'h1);
    chk("irq_set_wins", 32'(irq), 32'h1);
    reg_read(3'd5, 32'h1);
    reg_write(3'd3, 32'h0);
    chk("irq_after_en_clr", 32'(irq), 32'h1);
    reg_write(3'd5, 32'h1);
    chk("irq_w1c", 32'(irq), 32'h0);
    reg_read(3'd5, 32'h0);

    // Edges on disabled bits are dropped, not latched
    gpio_in_buf[0] = 1'b0;
    repeat (IN_LAT + 2) cyc();
    gpio_in_buf[0] = 1'b1;
    repeat (IN_LAT + 2) cyc();
    reg_write(3'd3, 32'h1);
    repeat (2) cyc();
    reg_read(3'd5, 32'h0);
    chk("irq_disabled", 32'(irq), 32'h0);

`ifdef MGMT_GPIO_DEBOUNCE_EN
    // Short glitch filtered, long pulse accepted
    reg_write(3'd3, 32'h8);
    gpio_in_buf[3] = 1'b1;
    repeat (5) cyc();
    gpio_in_buf[3] = 1'b0;
    repeat (14) cyc();
    reg_read(3'd2, 32'h1);
    reg_read(3'd5, 32'h0);
    gpio_in_buf[3] = 1'b1;
    repeat (11) cyc();
    reg_read(3'd2, 32'h9);
    gpio_in_buf[3] = 1'b0;
    repeat (12) cyc();
    reg_read(3'd5, 32'h8);
    reg_write(3'd5, 32'h8);
    reg_read(3'd5, 32'h0);
`endif

    // Falling on bit 0 and rising on bit 1 together
    reg_write(3'd3, 32'h2);
    reg_write(3'd4, 32'h1);
    gpio_in_buf[0] = 1'b0;
    gpio_in_buf[1] = 1'b1;
    repeat (IN_LAT + 2) cyc();
    reg_read(3'd5, 32'h3);
    chk("irq_pend3", 32'(irq), 32'h1);
    reg_write(3'd0, 32'hFF);
    chk("out_ff", 32'(gpio_out), 32'hFF);
    reg_read(3'd5, 32'h3);
    cyc();

    // Reset in the middle of a write
    reg_wr = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h777;
    resetn = 1'b0;
    gpio_in_buf = 19'h0;
    #1;
    chk("mid_rst_out", 32'(gpio_out), 32'h0);
    chk("mid_rst_oeb", 32'(gpio_oeb), 32'h7);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", reg_rdata, 32'h0);
    chk("mid_rst_rvalid", 32'(reg_rvalid), 32'h0);
    reg_wr = 1'b0;
    repeat (3) cyc();
    resetn = 1'b1;
    repeat (6) cyc();
    chk("post_rst2_irq", 32'(irq), 32'h0);
    reg_read(3'd5, 32'h0);
    reg_read(3'd2, 32'h0);
    reg_read(3'd1, 32'h7);
    reg_read(3'd0, 32'h0);
    repeat (2) cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
